// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   Instruction-fetch (IF) stage of a three-stage RISC-V pipeline. It owns
//   the PC, keeps at most one instruction-memory request in flight, and
//   writes each returned instruction into the IF/EX pipeline registers.
//   It accepts redirects from execute, which flush the pipe with a NOP
//   bubble. It also accepts stalls from execute. A response that arrives
//   during a stall is parked in a one-entry holding buffer.
//
//   State | meaning
//   IDLE  | one settling cycle after reset
//   REQ   | request at pc (held off while the holding buffer is full)
//   RESP  | waiting for the response to the outstanding request
//   DROP  | waiting for a response that a redirect made stale; it is discarded
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   imem_req/addr   fetch request and its address (always the current pc)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid
//   imem_rdata      response instruction
//   ex_stall        execute cannot take a new instruction
//   redirect_valid  taken branch/jump from execute
//   redirect_pc     target of that branch/jump
//   if_valid        IF/EX register holds a real instruction
//   if_pc           PC of the instruction in IF/EX
//   if_instr        instruction in IF/EX (NOP_INSTR when not valid)

module pc_fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            ex_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;

  logic            handshake;
  logic            deliver;

  // While the holding buffer is full, no new fetch is issued. This keeps
  // the single buffer entry from being overrun.
  assign imem_req  = (state_q == S_REQ) && !hold_valid_q;
  assign imem_addr = pc_q;
  assign handshake = imem_req && imem_ready;

  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    deliver      = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (imem_rvalid) begin
          deliver = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // IF/EX update. Buffer fill and buffer drain never happen together,
    // because a full buffer blocks any new request.
    if (ex_stall) begin
      if (deliver) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = req_pc_q;
        hold_instr_d = imem_rdata;
      end
    end else if (hold_valid_q) begin
      hold_valid_d = 1'b0;
      if_valid_d   = 1'b1;
      if_pc_d      = hold_pc_q;
      if_instr_d   = hold_instr_q;
    end else if (deliver) begin
      if_valid_d   = 1'b1;
      if_pc_d      = req_pc_q;
      if_instr_d   = imem_rdata;
    end else begin
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
    end

    // A redirect overrides everything above. A request already accepted at
    // the old pc must have its response swallowed, which is what DROP does.
    // A response that lands in the same cycle as the redirect has been
    // consumed. Going back to REQ in that case stops DROP from waiting for
    // a response that will never arrive.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      hold_valid_d = 1'b0;
      if_valid_d   = 1'b0;
      if_pc_d      = if_pc_q;
      if_instr_d   = NOP_INSTR;
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = handshake ? S_DROP : S_REQ;
        S_RESP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ex_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;
  logic auto_mem;

  always #5 clk = ~clk;

  pc_fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ex_stall(ex_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // One clock. The handshake is sampled just before the edge. When
  // auto_mem is set, the memory answers one cycle after each handshake.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem_req && imem_ready;
    a  = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = hs;
      imem_rdata  = hs ? instr_of(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b1; ex_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; auto_mem = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RST_PC); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
    checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", if_instr, NOP); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    do_reset();
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL free_first_req got req=%b addr=%h exp 1 %h", imem_req, imem_addr, RST_PC); end
    for (int i = 0; i < 3; i++) begin
      exp_pc = RST_PC + 32'(4 * i);
      step();
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL free_resp_cycle%0d got valid=%b req=%b exp 0 0", i, if_valid, imem_req); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
        errors++; $display("FAIL free_deliver%0d got v=%b pc=%h in=%h exp 1 %h %h", i, if_valid, if_pc, if_instr, exp_pc, instr_of(exp_pc));
      end
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc + 32'd4) begin errors++; $display("FAIL free_next_addr%0d got req=%b addr=%h exp 1 %h", i, imem_req, imem_addr, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_ready_stall();
    do_reset();
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || if_valid !== 1'b0) begin
        errors++; $display("FAIL ready_hold%0d got req=%b addr=%h v=%b exp 1 %h 0", i, imem_req, imem_addr, if_valid, RST_PC);
      end
    end
    imem_ready = 1'b1;
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin errors++; $display("FAIL ready_release got v=%b pc=%h exp 1 %h", if_valid, if_pc, RST_PC); end
  endtask

  task automatic test_ex_stall();
    do_reset();
    step(); step(); step();
    ex_stall = 1'b1;
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== instr_of(RST_PC) || imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_hold got v=%b pc=%h in=%h req=%b exp 1 %h %h 0", if_valid, if_pc, if_instr, imem_req, RST_PC, instr_of(RST_PC));
    end
    step();
    checks++; if (imem_req !== 1'b0 || if_pc !== RST_PC) begin errors++; $display("FAIL stall_hold2 got req=%b pc=%h exp 0 %h", imem_req, if_pc, RST_PC); end
    ex_stall = 1'b0;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4000_0004 || if_instr !== instr_of(32'h4000_0004)) begin
      errors++; $display("FAIL stall_drain got v=%b pc=%h in=%h exp 1 40000004 %h", if_valid, if_pc, if_instr, instr_of(32'h4000_0004));
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0008) begin errors++; $display("FAIL stall_next_req got req=%b addr=%h exp 1 40000008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step(); step(); step(); step();
    auto_mem = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h4000_0100;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL redir_flush got v=%b in=%h exp 0 %h", if_valid, if_instr, NOP); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4000_0100) begin errors++; $display("FAIL redir_drop_wait got req=%b addr=%h exp 0 40000100", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL redir_late_dropped got v=%b in=%h exp 0 %h", if_valid, if_instr, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0100) begin errors++; $display("FAIL redir_new_req got req=%b addr=%h exp 1 40000100", imem_req, imem_addr); end
    auto_mem = 1'b1;
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4000_0100 || if_instr !== instr_of(32'h4000_0100)) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h in=%h exp 1 40000100 %h", if_valid, if_pc, if_instr, instr_of(32'h4000_0100));
    end
  endtask

  task automatic test_redirect_stall_rvalid();
    do_reset();
    step(); step();
    ex_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4000_0200;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
      errors++; $display("FAIL flush_wins got v=%b pc=%h in=%h exp 0 0 %h", if_valid, if_pc, if_instr, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0200) begin errors++; $display("FAIL flush_buf_empty got req=%b addr=%h exp 1 40000200", imem_req, imem_addr); end
    step();
    ex_stall = 1'b0;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4000_0200 || if_instr !== instr_of(32'h4000_0200)) begin
      errors++; $display("FAIL flush_target got v=%b pc=%h in=%h exp 1 40000200 %h", if_valid, if_pc, if_instr, instr_of(32'h4000_0200));
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    step();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got req=%b addr=%h exp 1 fffffffc", imem_req, imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    rst = 1'b1;
    step();
    checks++; if (if_valid !== 1'b0 || imem_addr !== RST_PC || imem_req !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset got v=%b addr=%h req=%b in=%h pc=%h exp 0 %h 0 %h 0", if_valid, imem_addr, imem_req, if_instr, if_pc, RST_PC, NOP);
    end
    rst = 1'b0;
    auto_mem = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0; auto_mem = 1'b1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL idle_late_rvalid got v=%b req=%b addr=%h exp 0 1 %h", if_valid, imem_req, imem_addr, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ready_stall();
    test_ex_stall();
    test_redirect();
    test_redirect_stall_rvalid();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
